// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem -- pipelined, byte-addressed instruction memory with a load port.
//
// A read request (REQ high) is accepted every cycle. Its response comes out
// LATENCY cycles later with RVALID=1. Responses keep request order and there
// is no backpressure. Misaligned or out-of-range reads return RD=0 and raise
// MISALIGN and/or OOR. The load port (WE/WA/WD) writes one aligned, in-range
// word per cycle and silently drops any other write.
//
// Parameters
//   WIDTH   : data word width in bits (8..64, multiple of 8)
//   DEPTH   : number of words (power of 2, 2..4096)
//   LATENCY : read latency in cycles (1..4)
//
// Ports
//   CLK      in   clock, all state on rising edge
//   RST_N    in   asynchronous active-low reset
//   REQ      in   read request
//   A        in   read byte address (32 bits)
//   RD       out  read data (WIDTH bits)
//   RVALID   out  RD and fault flags valid this cycle
//   MISALIGN out  returned read had a misaligned address
//   OOR      out  returned read had an out-of-range address
//   WE       in   load-port write enable
//   WA       in   load-port byte address (32 bits)
//   WD       in   load-port write data (WIDTH bits)
// -----------------------------------------------------------------------------
module inst_mem #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ,
    input  logic [31:0]      A,
    output logic [WIDTH-1:0] RD,
    output logic             RVALID,
    output logic             MISALIGN,
    output logic             OOR,
    input  logic             WE,
    input  logic [31:0]      WA,
    input  logic [WIDTH-1:0] WD
);

    localparam logic [31:0] BYTES   = 32'(WIDTH / 8);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam int          AW      = $clog2(DEPTH);

    // NOTE: the array has no reset. Contents survive RST_N and start at zero
    // only through this power-up initialiser. A reset loop over every word
    // would also stop the array from mapping onto block RAM.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Address decode for the read and load ports.
    logic [31:0] r_word;
    logic [31:0] w_word;
    logic        r_mis;
    logic        r_oor;
    logic        w_ok;

    assign r_word = A / BYTES;
    assign r_mis  = (A % BYTES) != 32'd0;
    assign r_oor  = r_word >= DEPTH_W;
    assign w_word = WA / BYTES;
    assign w_ok   = ((WA % BYTES) == 32'd0) && (w_word < DEPTH_W);

    // Load port. RST_N gates the enable so writes are ignored while in reset.
    always_ff @(posedge CLK) begin
        if (RST_N && WE && w_ok) begin
            mem[w_word[AW-1:0]] <= WD;
        end
    end

    // Response pipeline. Stage 0 is loaded straight from the array, so the
    // array read happens at the request edge. Same-edge writes therefore are
    // not seen yet, which gives old-data-first ordering. The address is used
    // only at the request edge, so later changes to A do not reach in-flight
    // responses. Each stage loads only when its input is valid. The last stage
    // drives the outputs, so RD and the flags hold while RVALID is low.
    logic [LATENCY-1:0] stg_valid;
    logic [LATENCY-1:0] stg_mis;
    logic [LATENCY-1:0] stg_oor;
    logic [WIDTH-1:0]   stg_data [LATENCY];

    // NOTE: sequential state uses non-blocking assignments only. Every stage
    // then reads the value its neighbour held before this edge, which is what
    // makes the shift behave like a pipeline and not a single wire.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stg_valid <= '0;
            stg_mis   <= '0;
            stg_oor   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_data[i] <= '0;
            end
        end else begin
            stg_valid[0] <= REQ;
            if (REQ) begin
                stg_mis[0]  <= r_mis;
                stg_oor[0]  <= r_oor;
                stg_data[0] <= (r_mis || r_oor) ? '0 : mem[r_word[AW-1:0]];
            end
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                if (stg_valid[i-1]) begin
                    stg_mis[i]  <= stg_mis[i-1];
                    stg_oor[i]  <= stg_oor[i-1];
                    stg_data[i] <= stg_data[i-1];
                end
            end
        end
    end

    assign RVALID   = stg_valid[LATENCY-1];
    assign RD       = stg_data[LATENCY-1];
    assign MISALIGN = stg_mis[LATENCY-1];
    assign OOR      = stg_oor[LATENCY-1];

endmodule
